xbar_lrg_arbiter: RTL and testbench
===================================

Name: xbar_lrg_arbiter

Overview:
- Parametrised crosspoint arbiter for the generic crossbar. It grants one of N requesters ownership of an output port, and the owner holds the port until it releases it.
- Fairness: least-recently-granted (LRG) priority matrix, legal for any N ≥ 2.
- Adds a two-level QoS class and an optional maximum-hold timeout that preempts a long-running owner.
- One instance per crossbar output, fed by per-input req/rel lines.

Parameters:
- N, 4, number of requesters (≥2, any value).
- MAX_HOLD, 0, cycles an owner may hold the grant while others wait; 0 disables preemption.
- IDW, $clog2(N) (min 1), width of grant_id.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request level.
- req_hp  input  N  high-priority qualifier; ignored where req=0.
- rel  input  N  release strobe; honoured only from the current owner.
- grant  output  N  one-hot (or zero) registered grant.
- grant_valid  output  1  |grant.
- grant_id  output  IDW  index of granted requester; 0 when grant_valid=0.
- preempt  output  1  one-cycle pulse: the grant was taken by timeout this cycle.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock. All state is in flops cleared or preset by reset.
- Reset values: grant=0, grant_valid=0, grant_id=0, preempt=0, hold counter=0.
- Priority matrix reset: blk[i][j]=1 iff j<i, so requester 0 is highest. blk[i][j]=1 means j beats i. Diagonal is always 0.
- Eligible set E: if any req&req_hp, then E=req&req_hp; else E=req.
- Candidate i wins iff i∈E and no j∈E with blk[i][j]=1. Exactly one winner whenever E≠0.
- Arbitration opportunity exists when:
  - the port is idle (grant=0), or
  - rel[owner]=1, or
  - a timeout fires.
- On an opportunity with a winner w:
  - grant<=onehot(w) at the next clock edge, so latency from req to grant is 1 cycle.
  - Matrix update: blk[w][j]<=1 and blk[j][w]<=0 for all j≠w, making w the lowest priority.
- Back-to-back handoff: if rel[owner]=1 in cycle t and another requester is eligible, the new grant appears at t+1 with no idle cycle. The releasing owner is excluded from E in that cycle.
- rel[owner]=1 with no other eligible requester: grant<=0 at t+1; matrix unchanged.
- Owner dropping req without asserting rel: grant is held, and rel is still required.
- rel from a non-owner: ignored.
- Idle with E=0: grant stays 0; matrix unchanged.
- Hold counter:
  - Cleared whenever grant changes or is idle.
  - Increments each cycle the owner holds while E excluding the owner is non-zero; saturates at MAX_HOLD.
- Timeout: counter==MAX_HOLD with others waiting (MAX_HOLD>0).
  - Arbitrate among E minus the owner.
  - grant switches directly to the winner at the next edge.
  - preempt=1 for that one cycle (registered, coincident with the new grant).
  - The preempted owner is treated as granted, so it stays lowest priority.
- Simultaneous rel[owner] and timeout: rel wins; preempt stays 0.
- Reset mid-hold: grant drops asynchronously; the matrix returns to its reset order.
- Grant is always one-hot or zero; assertion-checked.

Decomposition:
- Package xbar_arb_pkg holds:
  - function lrg_reset_matrix(N), returning the reset matrix.
  - function onehot2idx.
  - hold-counter width constant HOLD_W = $clog2(MAX_HOLD+1) (min 1).
- Sub-module lrg_matrix_pick: purely combinational. Takes blk[N][N] and the eligible vector; produces a one-hot winner and a found flag. It is instantiated once, with the eligible vector pre-masked for release and timeout cases.
- The top holds the matrix flops, owner register, hold counter, and preempt flop.

Test Plan (N=4 unless noted):
- Reset, then req=4'b1010 → at cycle+1 grant=4'b0010, grant_id=1. Matrix order afterwards is 0,2,3,1.
- Owner 1 holds. req=4'b1011; rel[1]=1 at t → grant=4'b0001 at t+1 with no gap. Then rel[0] → grant=4'b1000.
- req=4'b1111 with req_hp=4'b0100, idle → grant=4'b0100 despite 0 having higher LRG rank. With hp cleared, next arbitration picks 0.
- MAX_HOLD=3: owner 2 holds while req[0] is pending → after 3 counted cycles grant=4'b0001 and preempt=1 for exactly one cycle. Same setup with rel[2] on the timeout cycle → preempt=0.
- rel from non-owner 3 while owner 0 holds → grant unchanged. Owner 0 drops req without rel → grant still 4'b0001.
- Assert reset mid-hold → grant=0 immediately. After release, req=4'b1111 → grant=4'b0001. Randomised run with N=5 checks one-hot grant and that no requester is starved beyond N-1 grants.

Source files
------------

// File: rtl/xbar_lrg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbar_arb_pkg
// Description : Shared helpers for the crossbar LRG arbiter (reset priority
//               matrix, one-hot decode, hold-counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package xbar_arb_pkg;

   // Upper bound on requesters; the flat reset matrix is sized from it.
   localparam int MAX_N = 32;

   typedef logic [MAX_N-1:0] vec_t;

   // Bit i*MAX_N+j set means j beats i; lower index wins at reset.
   function automatic logic [MAX_N*MAX_N-1:0] lrg_reset_matrix(input int n);
      logic [MAX_N*MAX_N-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_N; i++) begin
         for (int j = 0; j < MAX_N; j++) begin
            if ((i < n) && (j < n) && (j < i)) begin
               m[i*MAX_N+j] = 1'b1;
            end
         end
      end
      return m;
   endfunction

   function automatic int unsigned onehot2idx(input vec_t v);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (v[i]) begin
            idx = idx | unsigned'(i);
         end
      end
      return idx;
   endfunction

   function automatic int hold_width(input int max_hold);
      return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_lrg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : xbar_lrg_arbiter_if
// Description : Request/grant bundle between crossbar inputs and one
//               output-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface xbar_lrg_arbiter_if #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
);
   logic [N-1:0]   req;
   logic [N-1:0]   req_hp;
   logic [N-1:0]   rel;
   logic [N-1:0]   grant;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic           preempt;

   modport master (
      output req, req_hp, rel,
      input  grant, grant_valid, grant_id, preempt
   );

   modport slave (
      input  req, req_hp, rel,
      output grant, grant_valid, grant_id, preempt
   );
endinterface
`default_nettype wire

// File: rtl/xbar_lrg_arbiter_lrg_matrix_pick.sv
`default_nettype none
// ============================================================================
// Module      : lrg_matrix_pick
// Description : Combinational winner selection from an LRG priority matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module lrg_matrix_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0][N-1:0] blk_i,
   input  logic [N-1:0]        elig_i,
   output logic [N-1:0]        win_o,
   output logic                found_o
);

   // A candidate wins when no other eligible requester blocks it.
   always_comb begin
      win_o = '0;
      for (int i = 0; i < N; i++) begin
         win_o[i] = elig_i[i] & ~(|(elig_i & blk_i[i]));
      end
   end

   assign found_o = |elig_i;

endmodule
`default_nettype wire

// File: rtl/xbar_lrg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xbar_lrg_arbiter
// Description : Per-output crosspoint arbiter: LRG fairness, two-level QoS,
//               owner-held grant with optional max-hold preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_lrg_arbiter
   import xbar_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clock,
   input  logic              reset,
   xbar_lrg_arbiter_if.slave arb_if
);

   localparam int                     HOLD_W  = hold_width(MAX_HOLD);
   localparam logic [HOLD_W-1:0]      HOLD_MX = HOLD_W'(MAX_HOLD);
   localparam logic [MAX_N*MAX_N-1:0] RST_BLK = lrg_reset_matrix(N);

   logic [N-1:0][N-1:0] blk_q, blk_d;
   logic [N-1:0]        grant_q, grant_d;
   logic                preempt_q, preempt_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;

   logic [N-1:0] w_req_oth;
   logic [N-1:0] w_hp_oth;
   logic [N-1:0] w_elig;
   logic [N-1:0] w_win;
   logic         w_found;
   logic         w_idle;
   logic         w_rel_own;
   logic         w_timeout;
   logic         w_opp;

   // The current owner never competes: this covers release handoff and
   // timeout re-arbitration with a single picker.
   assign w_req_oth = arb_if.req & ~grant_q;
   assign w_hp_oth  = w_req_oth & arb_if.req_hp;
   assign w_elig    = (|w_hp_oth) ? w_hp_oth : w_req_oth;

   assign w_idle    = ~(|grant_q);
   assign w_rel_own = |(arb_if.rel & grant_q);

   generate
      if (MAX_HOLD > 0) begin : g_timeout
         assign w_timeout = ~w_idle & (hold_q == HOLD_MX) & (|w_elig);
      end else begin : g_no_timeout
         assign w_timeout = 1'b0;
      end
   endgenerate

   assign w_opp = w_idle | w_rel_own | w_timeout;

   lrg_matrix_pick #(
      .N (N)
   ) u_pick (
      .blk_i   (blk_q),
      .elig_i  (w_elig),
      .win_o   (w_win),
      .found_o (w_found)
   );

   always_comb begin
      blk_d     = blk_q;
      grant_d   = grant_q;
      preempt_d = 1'b0;
      hold_d    = hold_q;

      if (w_opp) begin
         grant_d = w_win;
         if (w_found) begin
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  if (i != j) begin
                     if (w_win[i]) begin
                        blk_d[i][j] = 1'b1;
                     end else if (w_win[j]) begin
                        blk_d[i][j] = 1'b0;
                     end
                  end
               end
            end
            // A release on the timeout cycle is a normal handoff.
            preempt_d = w_timeout & ~w_rel_own;
         end
      end

      if ((grant_d != grant_q) || ~(|grant_d)) begin
         hold_d = '0;
      end else if ((|w_elig) && (hold_q != HOLD_MX)) begin
         hold_d = hold_q + HOLD_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant_q   <= '0;
         preempt_q <= 1'b0;
         hold_q    <= '0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               blk_q[i][j] <= RST_BLK[i*MAX_N+j];
            end
         end
      end else begin
         grant_q   <= grant_d;
         preempt_q <= preempt_d;
         hold_q    <= hold_d;
         blk_q     <= blk_d;
      end
   end

   assign arb_if.grant       = grant_q;
   assign arb_if.grant_valid = |grant_q;
   assign arb_if.grant_id    = IDW'(onehot2idx(MAX_N'(grant_q)));
   assign arb_if.preempt     = preempt_q;

`ifndef SYNTHESIS
   a_grant_onehot0 : assert property (@(posedge clock) disable iff (reset)
      $onehot0(grant_q));
`endif

endmodule
`default_nettype wire

// File: tb/tb_xbar_lrg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_lrg_arbiter
// Description : Directed scoreboard bench (N=4, MAX_HOLD=3) plus a random
//               N=5 fairness run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_lrg_arbiter;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   xbar_lrg_arbiter_if #(.N(4)) a4 ();
   xbar_lrg_arbiter_if #(.N(5)) a5 ();

   xbar_lrg_arbiter #(.N(4), .MAX_HOLD(3)) u_dut (
      .clock  (clock),
      .reset  (reset),
      .arb_if (a4.slave)
   );

   xbar_lrg_arbiter #(.N(5), .MAX_HOLD(0)) u_dut5 (
      .clock  (clock),
      .reset  (reset),
      .arb_if (a5.slave)
   );

   typedef struct {
      string      name;
      logic [3:0] grant;
      logic [1:0] id;
      logic       pre;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   rand_on  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
      end
   endtask

   // Drive one cycle of stimulus; the expected post-edge outputs go to the scoreboard.
   task automatic step(input logic [3:0] rq, input logic [3:0] hp, input logic [3:0] rl,
                       input logic [3:0] eg, input logic [1:0] eid, input logic ep,
                       input string nm);
      exp_t e;
      @(negedge clock);
      a4.req    = rq;
      a4.req_hp = hp;
      a4.rel    = rl;
      e.name  = nm;
      e.grant = eg;
      e.id    = eid;
      e.pre   = ep;
      sb.push_back(e);
      @(posedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      a4.req    = '0;
      a4.req_hp = '0;
      a4.rel    = '0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Scoreboard monitor for the N=4 instance.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, " grant/valid/id"},
                32'({a4.grant_valid, a4.grant_id, a4.grant}),
                32'({|e.grant, e.id, e.grant}));
            chk({e.name, " preempt"}, 32'(a4.preempt), 32'(e.pre));
         end
      end
   end

   // Property monitor for the random N=5 run.
   initial begin
      logic [4:0] prev5;
      int         wc[5];
      int         id;
      prev5 = '0;
      for (int i = 0; i < 5; i++) wc[i] = 0;
      forever begin
         @(posedge clock);
         #1;
         if (rand_on) begin
            id = 0;
            for (int k = 0; k < 5; k++) if (a5.grant[k]) id = k;
            chk("n5 onehot grant", 32'($onehot0(a5.grant)), 32'd1);
            chk("n5 valid/id", 32'({a5.grant_valid, a5.grant_id}),
                32'({|a5.grant, 3'(id)}));
            if ((a5.grant != '0) && (a5.grant != prev5)) begin
               for (int i = 0; i < 5; i++) begin
                  if (a5.grant[i]) begin
                     wc[i] = 0;
                  end else if (a5.req[i]) begin
                     wc[i]++;
                     chk("n5 starvation bound", 32'(wc[i] <= 4), 32'd1);
                  end
               end
            end
            prev5 = a5.grant;
         end
      end
   end

   initial begin
      reset     = 1'b1;
      a4.req    = '0; a4.req_hp = '0; a4.rel = '0;
      a5.req    = '0; a5.req_hp = '0; a5.rel = '0;
      repeat (2) @(posedge clock);
      step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "reset state");
      @(negedge clock);
      reset = 1'b0;

      // LRG grant, handoff without a gap, release to idle
      step(4'b1010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0, "first grant");
      step(4'b1011, 4'b0000, 4'b0010, 4'b0001, 2'd0, 1'b0, "handoff 1->0");
      step(4'b1001, 4'b0000, 4'b0001, 4'b1000, 2'd3, 1'b0, "handoff 0->3");
      step(4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'd0, 1'b0, "release to idle");
      step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle no req");

      // QoS, non-owner release, owner dropping req
      do_reset();
      step(4'b1111, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, "hp wins");
      step(4'b1111, 4'b0000, 4'b0100, 4'b0001, 2'd0, 1'b0, "after hp picks 0");
      step(4'b1111, 4'b0000, 4'b1000, 4'b0001, 2'd0, 1'b0, "non-owner rel");
      step(4'b0110, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, "owner drops req");
      step(4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, "held no req");
      step(4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, "owner releases");

      // Max-hold preemption
      do_reset();
      step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "to grant 2");
      step(4'b0101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "to hold 1");
      step(4'b0101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "to hold 2");
      step(4'b0101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "to hold 3");
      step(4'b0101, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, "timeout preempt");
      step(4'b0101, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, "preempt one cycle");

      // Release on the timeout cycle
      do_reset();
      step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "rt grant 2");
      step(4'b0101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "rt hold 1");
      step(4'b0101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "rt hold 2");
      step(4'b0101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "rt hold 3");
      step(4'b0101, 4'b0000, 4'b0100, 4'b0001, 2'd0, 1'b0, "rel beats timeout");
      step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, "rt new owner holds");

      // Asynchronous reset mid-hold
      #3;
      reset  = 1'b1;
      a4.req = '0;
      #1;
      chk("async reset grant", 32'({a4.grant_valid, a4.grant_id, a4.grant}), 32'd0);
      chk("async reset preempt", 32'(a4.preempt), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      step(4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, "after reset order");

      // Random fairness run on N=5
      rand_on = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         for (int i = 0; i < 5; i++) begin
            if (a5.grant[i]) begin
               if ($urandom_range(2) == 0) begin
                  a5.rel[i] = 1'b1;
                  a5.req[i] = 1'b0;
               end else begin
                  a5.rel[i] = 1'b0;
               end
            end else begin
               a5.rel[i] = ($urandom_range(7) == 0);
               if (!a5.req[i] && ($urandom_range(1) == 1)) a5.req[i] = 1'b1;
            end
         end
      end
      @(negedge clock);
      rand_on = 1'b0;
      a5.req  = '0;
      a5.rel  = '0;

      repeat (2) @(posedge clock);
      #2;
      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
